wb_trace_serializer: RTL and testbench
======================================

# wb_trace_serializer

Serializes the two per-cycle writeback channels of the dual-issue pipeline into the single-record debug writeback interface (`debug_wb_pc` / `debug_wb_rf_wen` / `debug_wb_rf_wnum` / `debug_wb_rf_wdata`) consumed by the golden-trace comparator and the board-level trace port.

- Sits directly after the WB stage.
- Buffers up to `DEPTH` records in program order: channel 0 before channel 1 within a cycle.
- Drains one record per cycle.
- Back-pressures the pipeline when it nears full.

## Interface

Parameters:
- `DEPTH`, 8, FIFO entries; power of two, ≥ 4.
- `STALL_LEVEL`, `DEPTH-2`, occupancy at or above which `stall_o` asserts.

Ports:
- `sys_clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `wb0_en` in 1: channel 0 writes a register this cycle.
- `wb0_pc` in 32: channel 0 instruction PC.
- `wb0_rd` in 5: channel 0 destination register.
- `wb0_wdata` in 32: channel 0 write data.
- `wb1_en`, `wb1_pc`, `wb1_rd`, `wb1_wdata`: same widths as channel 0; channel 1 is the younger instruction.
- `stall_o` out 1: pipeline must not advance WB next cycle.
- `debug_wb_pc` out 32: PC of the emitted record.
- `debug_wb_rf_wen` out 4: `4'hf` when a record is emitted, else `4'h0`.
- `debug_wb_rf_wnum` out 5: destination of the emitted record.
- `debug_wb_rf_wdata` out 32: data of the emitted record.
- `count_o` out `$clog2(DEPTH)+1`: current occupancy.
- `overflow_o` out 1: sticky flag; at least one record was dropped.

## Operation

Push:
- Each cycle, accepted records are pushed in the order channel 0, then channel 1.
- An accepted record is an enabled one, subject to the Configuration filter.
- Pushes per cycle: 0–2.

Pop:
- When occupancy is non-zero, the head record pops each cycle.
- The popped record is registered onto the `debug_wb_*` outputs.

Occupancy and free space:
- Next occupancy = `count + pushes - pop`.
- Free space for this cycle's pushes = `DEPTH - count + pop`, so a simultaneous pop frees a slot in the same cycle.

Overflow:
- If pushes exceed free space, records are dropped youngest first: channel 1, then channel 0.
- `overflow_o` sets on any drop and stays set until reset. Stored records are never corrupted.

Stall:
- `stall_o = (count_o >= STALL_LEVEL)`, combinational from the registered count.
- When upstream honours `stall_o`, no overflow can occur.

Pointers and idle outputs:
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Full vs. empty is resolved by `count_o`.
- Idle cycle (nothing popped): `debug_wb_rf_wen = 4'h0`. `debug_wb_pc`, `debug_wb_rf_wnum` and `debug_wb_rf_wdata` hold their last values.

Reset values:
- `debug_wb_pc`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`, `debug_wb_rf_wen`: 0.
- `count_o`: 0. `overflow_o`: 0. `stall_o`: 0.
- Both pointers: 0.

Reset mid-operation:
- All buffered records are discarded; nothing is emitted afterwards.
- Inputs presented in the reset cycle are ignored.

## Timing

- A record sampled at edge E is written to storage at E.
- It becomes head no earlier than the cycle after E and appears on the outputs after edge E+1 when the FIFO was empty. Minimum latency: 2 edges.
- Throughput: 1 record/cycle out, 2 records/cycle in.
- A burst of k records with the FIFO empty drains in k consecutive cycles with no gaps.
- `stall_o` reflects occupancy after the previous edge. Upstream samples it in the same cycle.

## Configuration

`WB_TRACE_SKIP_R0_EN`:
- Defined: records with `rd == 0` are treated as not enabled. They are neither pushed nor emitted, matching golden traces that omit `$zero` writes.
- Undefined: every enabled record is pushed verbatim, including `rd == 0`.

## Structure

Package `wb_trace_pkg`:
- `wb_rec_t`, a packed struct of `pc[31:0]`, `rd[4:0]`, `wdata[31:0]`.
- Default `DEPTH`.

Sub-module `wb_trace_fifo`:
- 2-write/1-read circular buffer of `wb_rec_t`.
- Owns pointers, count and drop logic.
- The top level adds the filter, stall compare and output registers.

## Test plan

1. Single record, no push-side activity: `wb0_en=1, pc=0xbfc00000, rd=5, wdata=0x1234` for one cycle. Outputs after 2 edges are `wen=4'hf`, `pc=0xbfc00000`, `wnum=5`, `wdata=0x1234`. The following cycle shows `wen=0` with pc held.
2. Dual issue: ch0 `pc=0x100 rd=1` and ch1 `pc=0x104 rd=2` in the same cycle. Emits 0x100 then 0x104 on consecutive cycles.
3. Fill with stall honoured: drive both channels every cycle while `!stall_o` (`DEPTH=8`). `stall_o` rises at `count=6`, `overflow_o` stays 0, and all records emerge in order.
4. Forced overflow: ignore `stall_o` and push 2/cycle. With `count=8` and one pop, ch0 is stored and ch1 is dropped. `overflow_o=1` and stays 1 until reset.
5. Reset mid-burst: assert resetn=0 for one cycle with `count=5`. Next cycle `count_o=0`, `wen=0`, all outputs 0, and nothing further is emitted.
6. With `WB_TRACE_SKIP_R0_EN`: ch0 `rd=0`, ch1 `rd=3`. Only the `rd=3` record is emitted. Without the macro, both records are emitted.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types and defaults for the writeback trace serializer.
package wb_trace_pkg;

  localparam int WB_TRACE_DEPTH = 8;

  localparam logic [3:0] WEN_ON  = 4'hf;
  localparam logic [3:0] WEN_OFF = 4'h0;

  // One retired register write as seen by the trace comparator.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_rec_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Two-write / one-read circular buffer of writeback records.
// Channel 0 is written ahead of channel 1; when space runs short the younger
// record (channel 1) is dropped first and a sticky overflow flag is raised.
// A pop in the same cycle frees a slot for that cycle's pushes.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = WB_TRACE_DEPTH
) (
  input  logic                     sys_clk,
  input  logic                     resetn,
  input  logic                     push0_i,
  input  wb_rec_t                  rec0_i,
  input  logic                     push1_i,
  input  wb_rec_t                  rec1_i,
  output wb_rec_t                  head_o,
  output logic                     pop_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_rec_t         mem_q [DEPTH];
  wb_rec_t         mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            pop_s;
  logic [CW-1:0]   free_s;
  logic [CW-1:0]   need1_s;
  logic            acc0_s;
  logic            acc1_s;
  logic            drop_s;
  logic [PW-1:0]   widx1_s;

  // Admission: decide which pushes fit, given that a pop frees a slot now.
  always_comb begin
    pop_s   = (count_q != {CW{1'b0}});
    free_s  = CW'(DEPTH) - count_q + CW'(pop_s);
    acc0_s  = push0_i && (free_s >= CW'(1));
    need1_s = acc0_s ? CW'(2) : CW'(1);
    acc1_s  = push1_i && (free_s >= need1_s);
    drop_s  = (push0_i && !acc0_s) || (push1_i && !acc1_s);
    widx1_s = wptr_q + PW'(acc0_s);
  end

  // Next-state for storage, pointers, occupancy and the sticky drop flag.
  always_comb begin
    mem_d          = mem_q;
    mem_d[wptr_q]  = acc0_s ? rec0_i : mem_q[wptr_q];
    mem_d[widx1_s] = acc1_s ? rec1_i : mem_d[widx1_s];
    wptr_d         = wptr_q + PW'(acc0_s) + PW'(acc1_s);
    rptr_d         = rptr_q + PW'(pop_s);
    count_d        = count_q + CW'(acc0_s) + CW'(acc1_s) - CW'(pop_s);
    overflow_d     = overflow_q | drop_s;
  end

  // Control state, cleared by the synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; contents are don't-care while count is zero.
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
  end

  assign head_o     = mem_q[rptr_q];
  assign pop_o      = pop_s;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/wb_trace_serializer.sv
// Serializes the dual-issue writeback channels into the single-record
// debug_wb_* trace interface, one record per cycle, in program order.
// Optional build macro: WB_TRACE_SKIP_R0_EN -- when defined, writes to
// register 0 are filtered out before buffering.
module wb_trace_serializer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH       = WB_TRACE_DEPTH,
  parameter int STALL_LEVEL = DEPTH - 2
) (
  input  logic                    sys_clk,
  input  logic                    resetn,
  input  logic                    wb0_en,
  input  logic [31:0]             wb0_pc,
  input  logic [4:0]              wb0_rd,
  input  logic [31:0]             wb0_wdata,
  input  logic                    wb1_en,
  input  logic [31:0]             wb1_pc,
  input  logic [4:0]              wb1_rd,
  input  logic [31:0]             wb1_wdata,
  output logic                    stall_o,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            push0_s, push1_s;
  wb_rec_t         rec0_s, rec1_s;
  wb_rec_t         head_s;
  logic            pop_s;
  logic [CW-1:0]   count_s;

  logic [31:0]     pc_q, pc_d;
  logic [3:0]      wen_q, wen_d;
  logic [4:0]      wnum_q, wnum_d;
  logic [31:0]     wdata_q, wdata_d;

  // Push filter and record packing for both channels.
  always_comb begin
`ifdef WB_TRACE_SKIP_R0_EN
    push0_s = wb0_en && (wb0_rd != 5'd0);
    push1_s = wb1_en && (wb1_rd != 5'd0);
`else
    push0_s = wb0_en;
    push1_s = wb1_en;
`endif
    rec0_s = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
    rec1_s = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};
  end

  wb_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .resetn     (resetn),
    .push0_i    (push0_s),
    .rec0_i     (rec0_s),
    .push1_i    (push1_s),
    .rec1_i     (rec1_s),
    .head_o     (head_s),
    .pop_o      (pop_s),
    .count_o    (count_s),
    .overflow_o (overflow_o)
  );

  // Output record: load the popped head, otherwise hold fields and drop wen.
  always_comb begin
    if (pop_s) begin
      pc_d    = head_s.pc;
      wnum_d  = head_s.rd;
      wdata_d = head_s.wdata;
      wen_d   = WEN_ON;
    end else begin
      pc_d    = pc_q;
      wnum_d  = wnum_q;
      wdata_d = wdata_q;
      wen_d   = WEN_OFF;
    end
  end

  // Registered trace outputs.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      pc_q    <= 32'h0;
      wen_q   <= WEN_OFF;
      wnum_q  <= 5'd0;
      wdata_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      wen_q   <= wen_d;
      wnum_q  <= wnum_d;
      wdata_q <= wdata_d;
    end
  end

  assign stall_o           = (count_s >= CW'(STALL_LEVEL));
  assign count_o           = count_s;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = wen_q;
  assign debug_wb_rf_wnum  = wnum_q;
  assign debug_wb_rf_wdata = wdata_q;

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Directed bench for wb_trace_serializer (DEPTH=8, STALL_LEVEL=6).
module tb_wb_trace_serializer;

`ifdef WB_TRACE_SKIP_R0_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        resetn;
  logic        wb0_en, wb1_en;
  logic [31:0] wb0_pc, wb0_wdata, wb1_pc, wb1_wdata;
  logic [4:0]  wb0_rd, wb1_rd;
  logic        stall_o, overflow_o;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [3:0]  count_o;

  always #5 sys_clk = ~sys_clk;

  wb_trace_serializer #(.DEPTH(8), .STALL_LEVEL(6)) dut (
    .sys_clk(sys_clk), .resetn(resetn),
    .wb0_en(wb0_en), .wb0_pc(wb0_pc), .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata),
    .wb1_en(wb1_en), .wb1_pc(wb1_pc), .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata),
    .stall_o(stall_o), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic en0; logic [31:0] pc0; logic [4:0] rd0; logic [31:0] wd0;
    logic en1; logic [31:0] pc1; logic [4:0] rd1; logic [31:0] wd1;
    logic [3:0] e_wen; logic [31:0] e_pc; logic [4:0] e_wnum; logic [31:0] e_wd;
    logic [3:0] e_cnt; logic e_stall;
  } vec_t;

  function automatic vec_t mk(
    input logic e0, input logic [31:0] p0, input logic [4:0] r0, input logic [31:0] d0,
    input logic e1, input logic [31:0] p1, input logic [4:0] r1, input logic [31:0] d1,
    input logic [3:0] wen, input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd,
    input logic [3:0] cnt, input logic st);
    vec_t v;
    v.en0 = e0; v.pc0 = p0; v.rd0 = r0; v.wd0 = d0;
    v.en1 = e1; v.pc1 = p1; v.rd1 = r1; v.wd1 = d1;
    v.e_wen = wen; v.e_pc = pc; v.e_wnum = wn; v.e_wd = wd;
    v.e_cnt = cnt; v.e_stall = st;
    return v;
  endfunction

  // Reference model for the multi-cycle sequences.
  typedef struct { logic [31:0] pc; logic [4:0] rd; logic [31:0] wd; } rec_t;
  rec_t        exp_q[$];
  int          count_m = 0;
  bit          ovf_m   = 1'b0;
  logic [31:0] last_pc = 32'h0, last_wd = 32'h0;
  logic [4:0]  last_rn = 5'd0;
  int          emit_n  = 0;

  task automatic model_reset();
    exp_q.delete();
    count_m = 0; ovf_m = 1'b0;
    last_pc = 32'h0; last_wd = 32'h0; last_rn = 5'd0;
  endtask

  // One cycle: drive both channels, predict, clock, compare.
  task automatic step(
    input logic e0, input logic [31:0] p0, input logic [4:0] r0, input logic [31:0] d0,
    input logic e1, input logic [31:0] p1, input logic [4:0] r1, input logic [31:0] d1);
    bit   pop, q0, q1, a0, a1;
    int   free;
    rec_t h, n;
    q0 = e0 && !(SKIP && (r0 == 5'd0));
    q1 = e1 && !(SKIP && (r1 == 5'd0));
    pop = (count_m != 0);
    free = 8 - count_m + (pop ? 1 : 0);
    a0 = q0 && (free >= 1);
    a1 = q1 && (free >= (a0 ? 2 : 1));
    if ((q0 && !a0) || (q1 && !a1)) ovf_m = 1'b1;
    if (pop) begin
      h = exp_q.pop_front();
      last_pc = h.pc; last_rn = h.rd; last_wd = h.wd;
    end
    if (a0) begin n.pc = p0; n.rd = r0; n.wd = d0; exp_q.push_back(n); end
    if (a1) begin n.pc = p1; n.rd = r1; n.wd = d1; exp_q.push_back(n); end
    count_m = count_m + (a0 ? 1 : 0) + (a1 ? 1 : 0) - (pop ? 1 : 0);
    wb0_en = e0; wb0_pc = p0; wb0_rd = r0; wb0_wdata = d0;
    wb1_en = e1; wb1_pc = p1; wb1_rd = r1; wb1_wdata = d1;
    @(posedge sys_clk); #1;
    chk("seq_count", 32'(count_o), 32'(count_m));
    chk("seq_stall", 32'(stall_o), 32'(count_m >= 6));
    chk("seq_overflow", 32'(overflow_o), 32'(ovf_m));
    chk("seq_wen", 32'(debug_wb_rf_wen), pop ? 32'hf : 32'h0);
    chk("seq_pc", debug_wb_pc, last_pc);
    chk("seq_wnum", 32'(debug_wb_rf_wnum), 32'(last_rn));
    chk("seq_wdata", debug_wb_rf_wdata, last_wd);
    if (debug_wb_rf_wen == 4'hf) emit_n++;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
  endtask

  vec_t tbl[10];

  initial begin
    int   pushed;
    int   e0_n;
    bit   saw_stall;
    logic [31:0] pa;

    resetn = 1'b0;
    wb0_en = 1'b0; wb0_pc = 32'h0; wb0_rd = 5'd0; wb0_wdata = 32'h0;
    wb1_en = 1'b0; wb1_pc = 32'h0; wb1_rd = 5'd0; wb1_wdata = 32'h0;

    tbl[0] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 32'h0, 5'd0, 32'h0, 4'd0, 1'b0);
    tbl[1] = mk(1'b1, 32'hbfc00000, 5'd5, 32'h1234, 1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 32'h0, 5'd0, 32'h0, 4'd1, 1'b0);
    tbl[2] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 4'hf, 32'hbfc00000, 5'd5, 32'h1234, 4'd0, 1'b0);
    tbl[3] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 32'hbfc00000, 5'd5, 32'h1234, 4'd0, 1'b0);
    tbl[4] = mk(1'b1, 32'h100, 5'd1, 32'haa, 1'b1, 32'h104, 5'd2, 32'hbb, 4'h0, 32'hbfc00000, 5'd5, 32'h1234, 4'd2, 1'b0);
    tbl[5] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 4'hf, 32'h100, 5'd1, 32'haa, 4'd1, 1'b0);
    tbl[6] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 4'hf, 32'h104, 5'd2, 32'hbb, 4'd0, 1'b0);
    tbl[7] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 32'h104, 5'd2, 32'hbb, 4'd0, 1'b0);
    tbl[8] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h300, 5'd7, 32'h77, 4'h0, 32'h104, 5'd2, 32'hbb, 4'd1, 1'b0);
    tbl[9] = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 4'hf, 32'h300, 5'd7, 32'h77, 4'd0, 1'b0);

    repeat (2) @(posedge sys_clk);
    #1;
    resetn = 1'b1;

    // Table: reset state, single record, dual issue, channel-1-only record.
    for (int i = 0; i < 10; i++) begin
      wb0_en = tbl[i].en0; wb0_pc = tbl[i].pc0; wb0_rd = tbl[i].rd0; wb0_wdata = tbl[i].wd0;
      wb1_en = tbl[i].en1; wb1_pc = tbl[i].pc1; wb1_rd = tbl[i].rd1; wb1_wdata = tbl[i].wd1;
      @(posedge sys_clk); #1;
      chk($sformatf("v%0d_wen", i), 32'(debug_wb_rf_wen), 32'(tbl[i].e_wen));
      chk($sformatf("v%0d_pc", i), debug_wb_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_wnum", i), 32'(debug_wb_rf_wnum), 32'(tbl[i].e_wnum));
      chk($sformatf("v%0d_wdata", i), debug_wb_rf_wdata, tbl[i].e_wd);
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_overflow", i), 32'(overflow_o), 32'h0);
    end
    last_pc = 32'h300; last_rn = 5'd7; last_wd = 32'h77;

    // Fill with stall honoured: 20 records, no overflow, in order.
    pushed = 0; saw_stall = 1'b0; pa = 32'h1000;
    for (int c = 0; c < 50; c++) begin
      if (stall_o) saw_stall = 1'b1;
      if (!stall_o && pushed < 20) begin
        step(1'b1, pa, 5'd10, pa ^ 32'h5a5a0000, 1'b1, pa + 32'd4, 5'd11, pa ^ 32'ha5a50000);
        pa = pa + 32'd8; pushed += 2;
      end else begin
        idle();
      end
    end
    chk("fill_pushed", 32'(pushed), 32'd20);
    chk("fill_stall_seen", 32'(saw_stall), 32'h1);
    chk("fill_drained", 32'(exp_q.size()), 32'h0);

    // Register-0 records: filtered only when the skip build option is on.
    e0_n = emit_n;
    step(1'b1, 32'h400, 5'd0, 32'h11, 1'b1, 32'h404, 5'd3, 32'h22);
    repeat (4) idle();
    chk("r0_emitted", 32'(emit_n - e0_n), SKIP ? 32'd1 : 32'd2);

    // Forced overflow: push two per cycle ignoring stall.
    pa = 32'h2000;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, pa, 5'd12, pa, 1'b1, pa + 32'd4, 5'd13, pa + 32'd4);
      pa = pa + 32'd8;
    end
    chk("ovf_count_full", 32'(count_o), 32'd8);
    chk("ovf_set", 32'(overflow_o), 32'h1);
    repeat (12) idle();
    chk("ovf_sticky", 32'(overflow_o), 32'h1);
    chk("ovf_drained", 32'(exp_q.size()), 32'h0);

    // Reset mid-burst with count=5 and live inputs in the reset cycle.
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 32'h3000 + 32'(c * 8), 5'd14, 32'hc0de, 1'b1, 32'h3004 + 32'(c * 8), 5'd15, 32'hbeef);
    end
    chk("rst_pre_count", 32'(count_o), 32'd5);
    resetn = 1'b0;
    wb0_en = 1'b1; wb0_pc = 32'h4000; wb0_rd = 5'd9; wb0_wdata = 32'h99;
    wb1_en = 1'b1; wb1_pc = 32'h4004; wb1_rd = 5'd8; wb1_wdata = 32'h88;
    @(posedge sys_clk); #1;
    chk("rst_count", 32'(count_o), 32'h0);
    chk("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("rst_pc", debug_wb_pc, 32'h0);
    chk("rst_wnum", 32'(debug_wb_rf_wnum), 32'h0);
    chk("rst_wdata", debug_wb_rf_wdata, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);
    resetn = 1'b1;
    model_reset();
    repeat (8) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
